gb_regfile_mp: RTL

- Parametrised multi-port successor to the CPU register file. Holds the 8-bit architectural registers (A, F, B–L, W/Z temporaries) plus SP and PC as byte pairs.
- Serves NUM_RD independent ALU read ports, one bus read port and a 16-bit pair address output.
- Accepts same-cycle writes from the bus, the ALU, the flag unit and the IDU (16-bit pair write), resolving overlaps by fixed priority and counting conflicts.
- Sits between the decoder/ALU/IDU and the memory address mux.

---
 rtl/gb_regfile_pkg.sv | 57 +++++
 rtl/gb_regfile_wr_arb.sv | 88 ++++++++
 rtl/gb_regfile_mp.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gb_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_regfile_pkg
//  Description : Shared constants for the multi-port CPU register file:
//                byte/pair indices, write-source priority, F nibble mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_regfile_pkg;

  // Byte register indices (addresses 14..15 are reserved)
  localparam int NUM_BYTES = 14;
  localparam int REG_W   = 0;
  localparam int REG_Z   = 1;
  localparam int REG_A   = 2;
  localparam int REG_F   = 3;
  localparam int REG_B   = 4;
  localparam int REG_C   = 5;
  localparam int REG_D   = 6;
  localparam int REG_E   = 7;
  localparam int REG_H   = 8;
  localparam int REG_L   = 9;
  localparam int REG_SPH = 10;
  localparam int REG_SPL = 11;
  localparam int REG_PCH = 12;
  localparam int REG_PCL = 13;

  // 16-bit pair select; the high byte lives at the lower byte address
  typedef enum logic [2:0] {
    PAIR_WZ  = 3'd0,
    PAIR_AF  = 3'd1,
    PAIR_BC  = 3'd2,
    PAIR_DE  = 3'd3,
    PAIR_HL  = 3'd4,
    PAIR_SP  = 3'd5,
    PAIR_PC  = 3'd6,
    PAIR_RSV = 3'd7
  } pair_e;

  // Write source ranking: larger value wins a byte
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BUS  = 2'd1;
  localparam logic [1:0] SRC_ALU  = 2'd2;
  localparam logic [1:0] SRC_IDU  = 2'd3;

  // Bits of F that never hold state
  localparam logic [7:0] F_LO_MASK = 8'h0F;

  function automatic int pair_hi(input logic [2:0] p);
    return 2 * int'(p);
  endfunction

  function automatic int pair_lo(input logic [2:0] p);
    return 2 * int'(p) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gb_regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : gb_regfile_wr_arb
//  Description : Per-byte write resolution (IDU > ALU > bus), F merge and
//                flag override, plus same-cycle overlap detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_regfile_wr_arb
  import gb_regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic [NUM_BYTES-1:0][DATA_W-1:0] cur_i,
  input  logic                             bus_we_i,
  input  logic [ADDR_W-1:0]                bus_addr_i,
  input  logic [DATA_W-1:0]                bus_data_i,
  input  logic                             alu_we_i,
  input  logic [ADDR_W-1:0]                alu_addr_i,
  input  logic [DATA_W-1:0]                alu_data_i,
  input  logic [3:0]                       flag_we_i,
  input  logic [3:0]                       flag_in_i,
  input  logic                             idu_we_i,
  input  logic [2:0]                       idu_pair_i,
  input  logic [2*DATA_W-1:0]              idu_res_i,
  output logic [NUM_BYTES-1:0][DATA_W-1:0] next_o,
  output logic [NUM_BYTES-1:0]             wstrb_o,
  output logic                             conflict_o
);

  logic [NUM_BYTES-1:0]      bus_hit;
  logic [NUM_BYTES-1:0]      alu_hit;
  logic [NUM_BYTES-1:0]      idu_hit;
  logic [NUM_BYTES-1:0][1:0] src;

  // Decode which sources target each implemented byte; reserved targets never match
  always_comb begin
    bus_hit = '0;
    alu_hit = '0;
    idu_hit = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      bus_hit[i] = bus_we_i && (int'(bus_addr_i) == i);
      alu_hit[i] = alu_we_i && (int'(alu_addr_i) == i);
      idu_hit[i] = idu_we_i && (idu_pair_i != PAIR_RSV) &&
                   ((pair_hi(idu_pair_i) == i) || (pair_lo(idu_pair_i) == i));
    end
  end

  // Pick the winning source per byte, then apply F shaping and flag overrides
  always_comb begin
    next_o     = cur_i;
    wstrb_o    = '0;
    conflict_o = 1'b0;
    src        = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      src[i] = SRC_NONE;
      if (bus_hit[i]) src[i] = SRC_BUS;
      if (alu_hit[i]) src[i] = SRC_ALU;
      if (idu_hit[i]) src[i] = SRC_IDU;

      case (src[i])
        SRC_IDU: next_o[i] = (pair_hi(idu_pair_i) == i) ? idu_res_i[2*DATA_W-1:DATA_W]
                                                         : idu_res_i[DATA_W-1:0];
        SRC_ALU: next_o[i] = alu_data_i;
        SRC_BUS: next_o[i] = bus_data_i;
        default: next_o[i] = cur_i[i];
      endcase
      wstrb_o[i] = (src[i] != SRC_NONE);

      // Flag writes are merged afterwards and so never take part in overlap
      if ((bus_hit[i] && alu_hit[i]) || (bus_hit[i] && idu_hit[i]) ||
          (alu_hit[i] && idu_hit[i]))
        conflict_o = 1'b1;

      if (i == REG_F) begin
        for (int b = 0; b < DATA_W; b++) begin
          if (b < 8 && F_LO_MASK[b[2:0]]) next_o[i][b] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
          if (flag_we_i[k]) next_o[i][4+k] = flag_in_i[k];
        end
        wstrb_o[i] = wstrb_o[i] | (|flag_we_i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : gb_regfile_mp
//  Description : Multi-port CPU register file: byte registers, SP and PC,
//                NUM_RD ALU read ports, bus read port, pair address output,
//                prioritised multi-source writes and conflict counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_regfile_mp
  import gb_regfile_pkg::*;
#(
  parameter int                  DATA_W = 8,
  parameter int                  ADDR_W = 4,
  parameter int                  NUM_RD = 2,
  parameter int                  BYPASS = 1,
  parameter logic [2*DATA_W-1:0] SP_RST = 16'hFFFE,
  parameter int                  CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       alu_we,
  input  logic [ADDR_W-1:0]          alu_waddr,
  input  logic [DATA_W-1:0]          alu_res,
  input  logic [3:0]                 flag_we,
  input  logic [3:0]                 flag_in,
  input  logic                       idu_we,
  input  logic [2:0]                 idu_pair,
  input  logic [2*DATA_W-1:0]        idu_res,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [ADDR_W-1:0]          rda,
  output logic [DATA_W-1:0]          rd,
  input  logic [2:0]                 addr_sel,
  output logic [2*DATA_W-1:0]        addr_out,
  output logic [2*DATA_W-1:0]        sp,
  output logic [2*DATA_W-1:0]        pc,
  output logic                       conflict,
  output logic [CNT_W-1:0]           conflict_cnt
);

  // Reset image: everything zero except SP (high byte at the lower index)
  localparam logic [NUM_BYTES*DATA_W-1:0] c_rst_flat =
    (NUM_BYTES*DATA_W)'({SP_RST[DATA_W-1:0], SP_RST[2*DATA_W-1:DATA_W]}) << (REG_SPH*DATA_W);
  localparam logic [NUM_BYTES-1:0][DATA_W-1:0] c_rst_vals = c_rst_flat;

  logic [NUM_BYTES-1:0][DATA_W-1:0] regs_q;
  logic [NUM_BYTES-1:0][DATA_W-1:0] regs_d;
  logic [NUM_BYTES-1:0][DATA_W-1:0] view;
  logic [NUM_BYTES-1:0]             wstrb;
  logic                             conflict_d;
  logic                             conflict_q;
  logic [CNT_W-1:0]                 cnt_d;
  logic [CNT_W-1:0]                 cnt_q;

  gb_regfile_wr_arb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_arb (
    .cur_i      (regs_q),
    .bus_we_i   (we),
    .bus_addr_i (wa),
    .bus_data_i (wd),
    .alu_we_i   (alu_we),
    .alu_addr_i (alu_waddr),
    .alu_data_i (alu_res),
    .flag_we_i  (flag_we),
    .flag_in_i  (flag_in),
    .idu_we_i   (idu_we),
    .idu_pair_i (idu_pair),
    .idu_res_i  (idu_res),
    .next_o     (regs_d),
    .wstrb_o    (wstrb),
    .conflict_o (conflict_d)
  );

  // Read view: reset image while in reset, else resolved-next or stored bytes
  generate
    if (BYPASS != 0) begin : g_bypass
      assign view = rst ? c_rst_vals : regs_d;
    end else begin : g_stored
      assign view = rst ? c_rst_vals : regs_q;
    end
  endgenerate

  function automatic logic [DATA_W-1:0] byte_at(
    input logic [NUM_BYTES-1:0][DATA_W-1:0] v,
    input logic [ADDR_W-1:0]                a
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (int'(a) == i) r = v[i];
    end
    return r;
  endfunction

  // ALU read ports
  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign rd_data[k*DATA_W +: DATA_W] = byte_at(view, rd_addr[k*ADDR_W +: ADDR_W]);
    end
  endgenerate

  assign rd = byte_at(view, rda);
  assign sp = {view[REG_SPH], view[REG_SPL]};
  assign pc = {view[REG_PCH], view[REG_PCL]};

  // Pair mux onto the memory address path; the reserved pair reads as zero
  always_comb begin
    addr_out = '0;
    for (int p = 0; p < 7; p++) begin
      if (int'(addr_sel) == p) addr_out = {view[pair_hi(3'(p))], view[pair_lo(3'(p))]};
    end
  end

  // Byte storage: commit strobed bytes, async reset to the reset image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= c_rst_vals;
    end else begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wstrb[i]) regs_q[i] <= regs_d[i];
      end
    end
  end

  // Saturating count of conflicting cycles
  always_comb begin
    cnt_d = cnt_q;
    if (conflict_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Conflict pulse and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire
